// File: rtl/spi_arb_pkg.sv
// Shared state encoding and default sizing for the SPI requester arbiter.
// The optional watchdog in spi_arbiter is enabled with SPI_ARB_TIMEOUT_EN.
package spi_arb_pkg;

  localparam int DEFAULT_NUM_REQ        = 2;
  localparam int DEFAULT_DATA_WIDTH     = 6;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: first requester after `last`, wrapping.
// Returns a one-hot winner, its index and whether anything was requesting.
module spi_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int               j;
  logic [IDX_W-1:0] jj;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    jj     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j  = (int'(last) + k) % NUM_REQ;
      jj = IDX_W'(j);
      if (!valid && req[jj]) begin
        valid      = 1'b1;
        idx        = jj;
        onehot[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master between NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add a WAIT watchdog that completes with ack_err.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          ack_err,
  output logic                          busy,
  output logic                          start_tx,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("spi_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  // Handshake: a requester raises req with its word on req_data and holds both
  // until its ack pulse; the word is captured on the grant edge, and a req
  // still high after ack counts as a fresh request behind any other pending one.

  arb_state_t state, state_n;

  logic [IDX_W-1:0]      last, last_n;
  logic [IDX_W-1:0]      win_idx, win_idx_n;
  logic [NUM_REQ-1:0]    grant_n, ack_n;
  logic                  ack_err_n, busy_n, start_tx_n;
  logic [DATA_WIDTH-1:0] tx_data_n, pick_word;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;
  logic                  tx_done_q, rise, timeout_hit;

  spi_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .last   (last),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_word = pick_word
                | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{pick_onehot[i]}});
    end
  end

  assign rise = tx_done & ~tx_done_q;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // wait_cnt holds the number of WAIT cycles already completed
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == ST_START) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    last_n     = last;
    win_idx_n  = win_idx;
    grant_n    = grant;
    ack_n      = '0;
    ack_err_n  = 1'b0;
    busy_n     = busy;
    start_tx_n = 1'b0;
    tx_data_n  = tx_data;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_n    = ST_START;
          win_idx_n  = pick_idx;
          grant_n    = pick_onehot;
          tx_data_n  = pick_word;
          busy_n     = 1'b1;
          start_tx_n = 1'b1;
        end
      end
      ST_START: state_n = ST_WAIT;
      ST_WAIT: begin
        if (rise || timeout_hit) begin
          state_n   = ST_DONE;
          ack_n     = grant;
          ack_err_n = ~rise;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        last_n  = win_idx;
        grant_n = '0;
        busy_n  = 1'b0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      last      <= IDX_W'(NUM_REQ - 1);
      win_idx   <= '0;
      grant     <= '0;
      ack       <= '0;
      ack_err   <= 1'b0;
      busy      <= 1'b0;
      start_tx  <= 1'b0;
      tx_data   <= '0;
      tx_done_q <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      win_idx   <= win_idx_n;
      grant     <= grant_n;
      ack       <= ack_n;
      ack_err   <= ack_err_n;
      busy      <= busy_n;
      start_tx  <= start_tx_n;
      tx_data   <= tx_data_n;
      tx_done_q <= tx_done;
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: round-robin model, word scoreboard and
// a scripted spi_master; the timeout scenario needs SPI_ARB_TIMEOUT_EN.
module tb_spi_arbiter;

  localparam int N     = 2;
  localparam int W     = 6;
  localparam int TO    = 16;
  localparam int LIMIT = 200;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N*W-1:0] req_data;
  logic [N-1:0] grant, ack;
  logic         ack_err, busy, start_tx, tx_done;
  logic [W-1:0] tx_data;

  int errors = 0;
  int checks = 0;
  int m_last;
  int win_q[$];
  logic [W-1:0] exp_q[$];

  spi_arbiter #(
    .NUM_REQ        (N),
    .DATA_WIDTH     (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .ack      (ack),
    .ack_err  (ack_err),
    .busy     (busy),
    .start_tx (start_tx),
    .tx_data  (tx_data),
    .tx_done  (tx_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset(input int cycles);
    reset    = 1'b0;
    req      = '0;
    tx_done  = 1'b0;
    req_data = '0;
    repeat (cycles) step();
    reset  = 1'b1;
    m_last = N - 1;
    win_q.delete();
    exp_q.delete();
  endtask

  // ---------------- reference model ----------------
  function automatic int model_winner(input logic [N-1:0] r, input int last_i);
    logic [N-1:0] rr;
    for (int k = 1; k <= N; k++) begin
      rr = r >> ((last_i + k) % N);
      if (rr[0]) return (last_i + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic logic [W-1:0] word_of(input int i);
    logic [N*W-1:0] tmp;
    tmp = req_data >> (i * W);
    return tmp[W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_word(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic post_request(input logic [N-1:0] r);
    int w;
    req = r;
    w   = model_winner(r, m_last);
    win_q.push_back(w);
    exp_q.push_back(word_of(w));
  endtask

  task automatic wait_start(output int lat);
    lat = -1;
    for (int i = 1; i <= LIMIT; i++) begin
      step();
      if (start_tx === 1'b1) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic wait_ack(output int lat);
    lat = -1;
    for (int i = 1; i <= LIMIT; i++) begin
      step();
      if (ack !== '0) begin
        lat = i;
        return;
      end
    end
  endtask

  // master model: tx_done rises after `delay` cycles and falls on the ack cycle
  task automatic run_done(input int delay, output int early, output int lat,
                          output logic [N-1:0] av, output logic ev);
    early = 0;
    repeat (delay) begin
      step();
      if (ack !== '0) early++;
    end
    tx_done = 1'b1;
    wait_ack(lat);
    av      = ack;
    ev      = ack_err;
    tx_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset(3);
    checks++; if (grant !== '0)     $display("FAIL reset_grant: got %b expected 0", grant);
    if (grant !== '0) errors++;
    checks++; if (ack !== '0)       begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b expected 0", ack_err); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (start_tx !== 1'b0) begin errors++; $display("FAIL reset_start_tx: got %b expected 0", start_tx); end
    checks++; if (tx_data !== '0)   begin errors++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || start_tx !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: busy=%b start_tx=%b expected 0/0", busy, start_tx);
    end
  endtask

  task automatic test_single();
    int lat, w, bad;
    logic [W-1:0] e;
    set_word(0, 6'h2A);
    post_request(2'b01);
    wait_start(lat);
    w = win_q.pop_front(); e = exp_q.pop_front();
    checks++; if (lat !== 1) begin errors++; $display("FAIL single_start_lat: got %0d expected 1", lat); end
    checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL single_grant: got %b expected %b", grant, onehot(w)); end
    checks++; if (tx_data !== e) begin errors++; $display("FAIL single_tx_data: got %h expected %h", tx_data, e); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    step();
    checks++; if (start_tx !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b expected 0", start_tx); end
    bad = 0;
    repeat (18) begin
      step();
      if (ack !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL single_early_ack: got %0d acks expected 0", bad); end
    tx_done = 1'b1;
    step();
    checks++;
    if (ack !== onehot(w) || ack_err !== 1'b0 || busy !== 1'b1 || grant !== onehot(w)) begin
      errors++; $display("FAIL single_ack: ack=%b err=%b busy=%b grant=%b expected ack=%b err=0 busy=1", ack, ack_err, busy, grant, onehot(w));
    end
    req = '0; tx_done = 1'b0; m_last = w;
    step();
    checks++;
    if (ack !== '0 || busy !== 1'b0 || grant !== '0) begin
      errors++; $display("FAIL single_after_ack: ack=%b busy=%b grant=%b expected all 0", ack, busy, grant);
    end
    step();
  endtask

  task automatic test_round_robin();
    int lat, w, early;
    logic [N-1:0] av;
    logic ev;
    logic [W-1:0] e;
    apply_reset(2);
    set_word(0, 6'h11); set_word(1, 6'h22);
    post_request(2'b11);
    for (int t = 0; t < 4; t++) begin
      wait_start(lat);
      w = win_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (lat !== ((t == 0) ? 1 : 2)) begin errors++; $display("FAIL rr_start_lat[%0d]: got %0d expected %0d", t, lat, (t == 0) ? 1 : 2); end
      checks++;
      if (grant !== onehot(w)) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", t, grant, onehot(w)); end
      checks++;
      if (tx_data !== e) begin errors++; $display("FAIL rr_tx_data[%0d]: got %h expected %h", t, tx_data, e); end
      run_done(3 + t, early, lat, av, ev);
      checks++;
      if (av !== onehot(w) || ev !== 1'b0 || early != 0 || lat !== 1) begin
        errors++; $display("FAIL rr_ack[%0d]: ack=%b err=%b early=%0d lat=%0d expected ack=%b err=0 early=0 lat=1", t, av, ev, early, lat, onehot(w));
      end
      m_last = w;
      if (t < 3) post_request(2'b11);
    end
    req = '0;
    step(); step();
  endtask

  task automatic test_stale_done();
    int lat, w, early;
    logic [W-1:0] e;
    set_word(0, 6'h0C); set_word(1, 6'h31);
    post_request(2'b11);
    wait_start(lat);
    w = win_q.pop_front(); e = exp_q.pop_front();
    checks++; if (lat !== 1 || tx_data !== e) begin errors++; $display("FAIL stale_first_start: lat=%0d data=%h expected 1/%h", lat, tx_data, e); end
    repeat (3) step();
    tx_done = 1'b1;
    wait_ack(lat);
    checks++; if (lat !== 1 || ack !== onehot(w)) begin errors++; $display("FAIL stale_first_ack: lat=%0d ack=%b expected 1/%b", lat, ack, onehot(w)); end
    m_last = w;
    post_request(2'b11);
    wait_start(lat);
    w = win_q.pop_front(); e = exp_q.pop_front();
    checks++;
    if (lat !== 2 || grant !== onehot(w) || tx_data !== e) begin
      errors++; $display("FAIL stale_second_start: lat=%0d grant=%b data=%h expected 2/%b/%h", lat, grant, tx_data, onehot(w), e);
    end
    early = 0;
    repeat (8) begin step(); if (ack !== '0) early++; end
    checks++; if (early != 0) begin errors++; $display("FAIL stale_level_ack: got %0d acks expected 0", early); end
    tx_done = 1'b0; step(); tx_done = 1'b1;
    wait_ack(lat);
    checks++; if (lat !== 1 || ack !== onehot(w)) begin errors++; $display("FAIL stale_second_ack: lat=%0d ack=%b expected 1/%b", lat, ack, onehot(w)); end
    tx_done = 1'b0; m_last = w;
    post_request(2'b11);
    wait_start(lat);
    w = win_q.pop_front(); e = exp_q.pop_front();
    checks++; if (lat !== 2 || grant !== onehot(w)) begin errors++; $display("FAIL start_rise_start: lat=%0d grant=%b expected 2/%b", lat, grant, onehot(w)); end
    tx_done = 1'b1;
    early = 0;
    repeat (6) begin step(); if (ack !== '0) early++; end
    checks++; if (early != 0) begin errors++; $display("FAIL start_rise_ignored: got %0d acks expected 0", early); end
    tx_done = 1'b0; step(); tx_done = 1'b1;
    wait_ack(lat);
    checks++; if (lat !== 1 || ack !== onehot(w)) begin errors++; $display("FAIL start_rise_ack: lat=%0d ack=%b expected 1/%b", lat, ack, onehot(w)); end
    tx_done = 1'b0; m_last = w; req = '0;
    step(); step();
  endtask

  task automatic test_data_change();
    int lat, w, early;
    logic [N-1:0] av;
    logic ev;
    logic [W-1:0] e;
    set_word(0, 6'h15);
    post_request(2'b01);
    wait_start(lat);
    w = win_q.pop_front(); e = exp_q.pop_front();
    step();
    set_word(0, 6'h3F);
    step(); step();
    checks++; if (tx_data !== e) begin errors++; $display("FAIL data_hold_wait: got %h expected %h", tx_data, e); end
    run_done(4, early, lat, av, ev);
    checks++;
    if (av !== onehot(w) || tx_data !== e || early != 0) begin
      errors++; $display("FAIL data_hold_ack: ack=%b data=%h early=%0d expected %b/%h/0", av, tx_data, early, onehot(w), e);
    end
    m_last = w;
    post_request(2'b01);
    wait_start(lat);
    w = win_q.pop_front(); e = exp_q.pop_front();
    checks++; if (lat !== 2 || tx_data !== e) begin errors++; $display("FAIL data_recapture: lat=%0d data=%h expected 2/%h", lat, tx_data, e); end
    run_done(2, early, lat, av, ev);
    checks++; if (av !== onehot(w) || lat !== 1) begin errors++; $display("FAIL data_recapture_ack: ack=%b lat=%0d expected %b/1", av, lat, onehot(w)); end
    m_last = w; req = '0;
    step(); step();
  endtask

  task automatic test_random_traffic();
    int lat, w, early, delay;
    logic [N-1:0] r, av;
    logic ev;
    logic [W-1:0] e;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N; i++) set_word(i, W'($urandom));
      r = N'($urandom_range(1, (1 << N) - 1));
      post_request(r);
      wait_start(lat);
      w = win_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (lat !== ((t == 0) ? 1 : 2) || grant !== onehot(w) || tx_data !== e) begin
        errors++; $display("FAIL rand_start[%0d]: lat=%0d grant=%b data=%h expected %0d/%b/%h", t, lat, grant, tx_data, (t == 0) ? 1 : 2, onehot(w), e);
      end
      step();
      for (int i = 0; i < N; i++) set_word(i, W'($urandom));
      if ($urandom_range(0, 1) == 1) req = '0;
      delay = $urandom_range(1, 10);
      run_done(delay, early, lat, av, ev);
      checks++;
      if (av !== onehot(w) || ev !== 1'b0 || early != 0 || lat !== 1 || tx_data !== e) begin
        errors++; $display("FAIL rand_ack[%0d]: ack=%b err=%b early=%0d lat=%0d data=%h expected %b/0/0/1/%h", t, av, ev, early, lat, tx_data, onehot(w), e);
      end
      m_last = w;
    end
    req = '0;
    step(); step();
  endtask

  task automatic test_reset_mid_wait();
    int lat, w, early;
    logic [N-1:0] av;
    logic ev;
    logic [W-1:0] e;
    set_word(1, 6'h05);
    post_request(2'b10);
    wait_start(lat);
    w = win_q.pop_front(); e = exp_q.pop_front();
    checks++; if (grant !== onehot(w) || tx_data !== e) begin errors++; $display("FAIL rst_mid_start: grant=%b data=%h expected %b/%h", grant, tx_data, onehot(w), e); end
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if (grant !== '0 || ack !== '0 || ack_err !== 1'b0 || busy !== 1'b0 || start_tx !== 1'b0 || tx_data !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: grant=%b ack=%b err=%b busy=%b start=%b data=%h expected all 0", grant, ack, ack_err, busy, start_tx, tx_data);
    end
    reset  = 1'b1;
    m_last = N - 1;
    win_q.delete(); exp_q.delete();
    set_word(0, 6'h1B);
    post_request(2'b11);
    wait_start(lat);
    w = win_q.pop_front(); e = exp_q.pop_front();
    checks++;
    if (lat !== 1 || grant !== onehot(w) || tx_data !== e) begin
      errors++; $display("FAIL rst_mid_regrant: lat=%0d grant=%b data=%h expected 1/%b/%h", lat, grant, tx_data, onehot(w), e);
    end
    run_done(3, early, lat, av, ev);
    checks++; if (av !== onehot(w) || early != 0) begin errors++; $display("FAIL rst_mid_ack: ack=%b early=%0d expected %b/0", av, early, onehot(w)); end
    m_last = w; req = '0;
    step(); step();
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int lat, w, early;
    logic [N-1:0] av;
    logic ev;
    logic [W-1:0] e;
    set_word(0, 6'h2D); set_word(1, 6'h12);
    tx_done = 1'b0;
    post_request(2'b11);
    wait_start(lat);
    w = win_q.pop_front(); e = exp_q.pop_front();
    early = 0;
    repeat (TO) begin step(); if (ack !== '0) early++; end
    checks++; if (early != 0) begin errors++; $display("FAIL timeout_early: got %0d acks expected 0", early); end
    step();
    checks++;
    if (ack !== onehot(w) || ack_err !== 1'b1) begin
      errors++; $display("FAIL timeout_ack: ack=%b err=%b expected %b/1", ack, ack_err, onehot(w));
    end
    m_last = w;
    post_request(2'b11);
    wait_start(lat);
    w = win_q.pop_front(); e = exp_q.pop_front();
    checks++;
    if (lat !== 2 || grant !== onehot(w) || tx_data !== e) begin
      errors++; $display("FAIL timeout_next: lat=%0d grant=%b data=%h expected 2/%b/%h", lat, grant, tx_data, onehot(w), e);
    end
    run_done(3, early, lat, av, ev);
    checks++; if (av !== onehot(w) || ev !== 1'b0) begin errors++; $display("FAIL timeout_next_ack: ack=%b err=%b expected %b/0", av, ev, onehot(w)); end
    m_last = w; req = '0;
    step(); step();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0; req = '0; req_data = '0; tx_done = 1'b0; m_last = N - 1;
    test_reset();
    test_single();
    test_round_robin();
    test_stale_done();
    test_data_change();
    test_random_traffic();
    test_reset_mid_wait();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and sequencer that shares one `spi_master` between `NUM_REQ` independent requesters. Each requester presents a data word and a request level. The arbiter grants one requester at a time, latches its word onto the master's `tx_data`, and pulses `start_tx`. It then waits for the master's `tx_done` and returns a one-cycle acknowledge to the winner. The block sits between the user logic (button/counter logic, sensors, etc.) and `spi_master`, and replaces direct drive of `start_tx`/`tx_data`.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, ≥2.
- `DATA_WIDTH`, default 6: SPI word width; must equal the master's `tx_data` width.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in clk cycles. Used only when `SPI_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  **synchronous, active-low** reset.
- `req`  in  NUM_REQ  request levels; bit i = requester i.
- `req_data`  in  NUM_REQ*DATA_WIDTH  word of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `grant`  out  NUM_REQ  one-hot; held from grant until ack; zero otherwise.
- `ack`  out  NUM_REQ  one-cycle pulse to the winner at transaction end.
- `ack_err`  out  1  pulses together with `ack` when the transaction timed out.
- `busy`  out  1  high from grant through the ack cycle.
- `start_tx`  out  1  one-cycle start pulse to `spi_master`.
- `tx_data`  out  DATA_WIDTH  latched winner word to `spi_master`.
- `tx_done`  in  1  completion from `spi_master`; treated as a level and rising-edge detected.

## Operation
- FSM states:
  - **IDLE**: if any `req` bit is set, pick the winner, then go to START.
  - **START**: for one cycle, `start_tx`=1; `grant`, `tx_data` and `busy` are valid. Always go to WAIT.
  - **WAIT**: wait for a `tx_done` rising edge, then go to DONE.
  - **DONE**: for one cycle, `ack[winner]`=1; update the round-robin pointer. Return to IDLE.
- Winner selection: search starts at requester `(last+1) mod NUM_REQ` and takes the first index with `req` set. `last` resets to NUM_REQ−1, so requester 0 wins first after reset.
- `tx_data` is captured from `req_data` on the grant edge. Changes to `req_data` or `req` after grant are ignored until the next IDLE.
- Requester rule: hold `req` until `ack`, and drop it in the cycle after `ack` if there is no further word.
- A `req` still high after its own `ack` is treated as a new request. Other pending requesters are served first.
- Dropping `req` during START or WAIT does not abort the transaction; `ack` is still issued.
- tx_done edge detect: `tx_done_q` is registered every cycle; `rise = tx_done & ~tx_done_q`.
  - Only a rise sampled in WAIT is accepted.
  - A rise in START is ignored. The master needs ≥2 cycles per word.
  - A `tx_done` level left high from the previous word does not complete the next one.

## Timing
- Reset values (`reset`=0 at a clk edge): state=IDLE, `grant`=0, `ack`=0, `ack_err`=0, `busy`=0, `start_tx`=0, `tx_data`=0, `tx_done_q`=0, `last`=NUM_REQ−1, timeout counter=0.
- Reset asserted mid-transaction aborts it immediately with no `ack`. The same `reset` must also reset `spi_master`.
- Request sampled in IDLE at edge t → `grant` and `start_tx` high in cycle t+1 → WAIT from t+2.
- `tx_done` rise sampled at edge k → `ack` in cycle k+1 → IDLE in k+2. The earliest next `start_tx` is k+3.
- Throughput overhead is 3 cycles per word on top of the SPI transfer.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SPI_ARB_TIMEOUT_EN`.
- **Defined**:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` with no rise, go to DONE and assert `ack[winner]` and `ack_err` together for one cycle.
  - The pointer advances as normal.
- **Undefined**:
  - WAIT lasts indefinitely.
  - `ack_err` is tied to 0.
  - No counter logic is synthesised; the `TIMEOUT_CYCLES` parameter remains but is unused.

## Structure
- Package `spi_arb_pkg`:
  - FSM state encoding constants (IDLE, START, WAIT, DONE; 2-bit).
  - Default `DATA_WIDTH`, `NUM_REQ` and `TIMEOUT_CYCLES` constants.
- Sub-module `spi_rr_picker`: purely combinational. Inputs are `req` and `last`; outputs are a one-hot winner and its index. Shared by any future arbiter in the design.
- Top `spi_arbiter` holds the FSM, data latch, edge detector and timeout counter.

## Test plan
- **Single requester.** Reset then release; req[0]=1 with data 6'h2A; master model asserts `tx_done` 20 cycles after `start_tx`.
  - Expect `start_tx` 1 cycle after req, `tx_data`=6'h2A, `grant`=2'b01, `ack[0]` 1 cycle after the `tx_done` rise.
- **Round robin.** req=2'b11 held continuously with data 6'h11 (requester 0) and 6'h22 (requester 1).
  - Expect grants alternating 0,1,0,1 and `tx_data` alternating 6'h11/6'h22.
- **Stale tx_done.** `tx_done` held high from the previous word into the next START.
  - Expect no early `ack`; completion occurs only after `tx_done` falls and rises again.
- **Data change after grant.** Change req_data[0] to 6'h3F during WAIT.
  - Expect `tx_data` to stay at its captured value until `ack`.
- **Reset mid-WAIT.** Drive `reset`=0 for 1 cycle during WAIT.
  - Expect all outputs 0 next cycle, no `ack`, and requester 0 granted first afterwards.
- **Timeout (SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16).** Master never asserts `tx_done`.
  - Expect `ack[0]` and `ack_err` pulsed in the cycle after WAIT cycle 16, then the next requester served.
